// File: rtl/term1_sched.sv
// Round-robin scheduler that time-shares one combinational term1 instance between NREQ requesters.
// Optional per-requester grant statistics are enabled with TERM1_SCHED_STATS_EN.

module term1_sched_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
endmodule

module term1_sched #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*34-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [33:0]             t1_in,
    input  logic [9:0]              t1_out,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [9:0]              rsp_data,
    input  logic                    rsp_ready,
    output logic                    busy
`ifdef TERM1_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]      grant_cnt
`endif
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_idx;
    logic            found;
    logic [33:0]     gnt_data;
    int              idx;

    // Search starts just past the last winner, so the last winner has lowest priority.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign gnt_data = req_data[int'(gnt_idx)*34 +: 34];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= IW'(NREQ - 1);
            t1_in     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        t1_in <= gnt_data;
                        rsp_id <= gnt_idx;
                        ptr    <= gnt_idx;
                        cnt    <= 4'(SETTLE - 1);
                        busy   <= 1'b1;
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= t1_out;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // Back to IDLE first: the next grant happens a cycle later.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef TERM1_SCHED_STATS_EN
    for (genvar k = 0; k < NREQ; k++) begin : g_stats
        term1_sched_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (req_valid[k] & req_ready[k]),
            .cnt (grant_cnt[k*16 +: 16])
        );
    end
`endif

endmodule

// File: tb/tb_term1_sched.sv
// Scoreboard bench for term1_sched: expected responses are queued at grant and checked on delivery.
// t1_out is modelled as a time-varying function of t1_in so the capture cycle is observable.

module tb_term1_sched;
    localparam int NREQ   = 4;
    localparam int SETTLE = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*34-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [33:0]         t1_in;
    logic [9:0]          t1_out;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [9:0]          rsp_data;
    logic                rsp_ready;
    logic                busy;
`ifdef TERM1_SCHED_STATS_EN
    logic [NREQ*16-1:0]  grant_cnt;
`endif

    term1_sched #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .t1_in     (t1_in),
        .t1_out    (t1_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef TERM1_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign t1_out = t1_in[33:24] ^ t1_in[9:0] ^ 10'(cyc);

    int passed = 0;
    int total  = 0;
    int mptr;
    logic [1:0] q_id[$];
    logic [9:0] q_data[$];

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 1; i <= NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [9:0] f_exp(input logic [33:0] d, input int at);
        return d[33:24] ^ d[9:0] ^ 10'(at);
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mptr = NREQ - 1;
        q_id.delete(); q_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (t1_in !== 34'h0) $display("FAIL reset_t1_in got %h want 0", t1_in); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", rsp_id); else passed++;
        total++; if (rsp_data !== 10'h0) $display("FAIL reset_rsp_data got %h want 0", rsp_data); else passed++;
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0000) $display("FAIL reset_idle_ready got %b want 0000", req_ready); else passed++;
        req_valid = 4'b1111; #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL reset_prio got %b want 0001", req_ready); else passed++;
        req_valid = 4'b0110; #1;
        total++; if (req_ready !== 4'b0010) $display("FAIL reset_prio2 got %b want 0010", req_ready); else passed++;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [33:0] d;
        int h;
        do_reset();
        d = 34'h3_0000_0001;
        req_data[33:0] = d; req_valid = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) $display("FAIL single_grant got %b want 0001", req_ready); else passed++;
        h = cyc;
        @(posedge clk); #1 req_valid = '0;
        total++; if (t1_in !== d) $display("FAIL single_t1_in got %h want %h", t1_in, d); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_early_c1 got %b want 0", rsp_valid); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL single_early_c2 got %b want 0", rsp_valid); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %b want 1", rsp_valid); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL single_rsp_id got %0d want 0", rsp_id); else passed++;
        total++; if (rsp_data !== f_exp(d, h + SETTLE)) $display("FAIL single_rsp_data got %h want %h", rsp_data, f_exp(d, h + SETTLE)); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_done got v=%b b=%b want 0 0", rsp_valid, busy); else passed++;
        total++; if (t1_in !== d) $display("FAIL single_t1_hold got %h want %h", t1_in, d); else passed++;
    endtask

    task automatic test_fairness();
        int seq[5] = '{0, 1, 2, 3, 0};
        int g = 0, last = 0;
        do_reset();
        for (int k = 0; k < NREQ; k++) req_data[k*34 +: 34] = 34'h1_2345_0000 + 34'(k * 37 + 5);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int c = 0; c < 60 && (g < 5 || q_id.size() != 0); c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready && q_id.size() != 0) begin
                total++; if (rsp_id !== q_id[0]) $display("FAIL fair_rsp_id got %0d want %0d", rsp_id, q_id[0]); else passed++;
                total++; if (rsp_data !== q_data[0]) $display("FAIL fair_rsp_data got %h want %h", rsp_data, q_data[0]); else passed++;
                void'(q_id.pop_front()); void'(q_data.pop_front());
            end
            if (req_ready != 0) begin
                total++; if (req_ready !== 4'(1 << seq[g])) $display("FAIL fair_order got %b want %b", req_ready, 4'(1 << seq[g])); else passed++;
                if (g > 0) begin
                    total++; if (cyc - last != SETTLE + 2) $display("FAIL fair_gap got %0d want %0d", cyc - last, SETTLE + 2); else passed++;
                end
                last = cyc;
                q_id.push_back(2'(seq[g]));
                q_data.push_back(f_exp(req_data[seq[g]*34 +: 34], cyc + SETTLE));
                g++;
                if (g == 5) begin
                    @(posedge clk); #1 req_valid = '0;
                end
            end
        end
        total++; if (g != 5 || q_id.size() != 0) $display("FAIL fair_timeout got grants=%0d pend=%0d want 5 0", g, q_id.size()); else passed++;
    endtask

    task automatic test_backpressure();
        logic [9:0] e_data;
        int h;
        bit seen = 0;
        do_reset();
        req_data[2*34 +: 34] = 34'h2_ABCD_5A5A; req_valid = 4'b0100; rsp_ready = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) $display("FAIL bp_grant got %b want 0100", req_ready); else passed++;
        h = cyc; e_data = f_exp(req_data[2*34 +: 34], h + SETTLE);
        @(posedge clk); #1 req_valid = '0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        total++; if (!seen || cyc - h != SETTLE + 1) $display("FAIL bp_latency got seen=%0d lat=%0d want 1 %0d", seen, cyc - h, SETTLE + 1); else passed++;
        @(posedge clk); #1 req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== e_data || req_ready !== 4'b0000)
                $display("FAIL bp_hold got v=%b id=%0d d=%h rdy=%b want 1 2 %h 0000", rsp_valid, rsp_id, rsp_data, req_ready, e_data);
            else passed++;
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        total++; if (req_ready !== 4'b0000) $display("FAIL bp_no_regrant got %b want 0000", req_ready); else passed++;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got %b want 0", rsp_valid); else passed++;
        total++; if (req_ready !== 4'b1000) $display("FAIL bp_next_rr got %b want 1000", req_ready); else passed++;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_settle();
        bit bad = 0;
        do_reset();
        req_data[3*34 +: 34] = 34'h0_FFFF_0123; req_valid = 4'b1000;
        @(negedge clk);
        total++; if (req_ready !== 4'b1000) $display("FAIL rs_grant got %b want 1000", req_ready); else passed++;
        @(posedge clk); #1 req_valid = '0;
        rst = 1'b1; #1;
        total++; if (busy !== 1'b0) $display("FAIL rs_busy got %b want 0", busy); else passed++;
        total++; if (t1_in !== 34'h0) $display("FAIL rs_t1_in got %h want 0", t1_in); else passed++;
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        total++; if (bad) $display("FAIL rs_no_rsp got pulse=1 want 0"); else passed++;
        @(posedge clk); #1 req_valid = 4'b1001; #1;
        total++; if (req_ready !== 4'b0001) $display("FAIL rs_prio got %b want 0001", req_ready); else passed++;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit mbusy = 0;
        int h = 0, p;
        logic [33:0] exp_t1;
        logic [NREQ-1:0] exp_rdy;
        int errs = 0;
        do_reset();
        exp_t1 = '0;
        for (int c = 0; c < 400 || (mbusy && c < 440); c++) begin
            @(posedge clk); #1;
            req_valid = (c < 400) ? 4'($urandom) : '0;
            for (int k = 0; k < NREQ; k++) req_data[k*34 +: 34] = {2'($urandom_range(0, 3)), 32'($urandom)};
            rsp_ready = (c >= 400) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            p = rr_pick(req_valid, mptr);
            exp_rdy = (!mbusy && p >= 0) ? 4'(1 << p) : '0;
            total++; if (req_ready !== exp_rdy) begin errs++; $display("FAIL rnd_ready got %b want %b", req_ready, exp_rdy); end else passed++;
            total++; if (busy !== mbusy) begin errs++; $display("FAIL rnd_busy got %b want %b", busy, mbusy); end else passed++;
            total++; if (t1_in !== exp_t1) begin errs++; $display("FAIL rnd_t1_in got %h want %h", t1_in, exp_t1); end else passed++;
            total++; if (rsp_valid !== (mbusy && cyc - h >= SETTLE + 1)) begin errs++; $display("FAIL rnd_rsp_valid got %b want %b", rsp_valid, mbusy && cyc - h >= SETTLE + 1); end else passed++;
            if (!mbusy) begin
                if (p >= 0) begin
                    mbusy = 1; h = cyc; mptr = p;
                    exp_t1 = req_data[p*34 +: 34];
                    q_id.push_back(2'(p));
                    q_data.push_back(f_exp(exp_t1, cyc + SETTLE));
                end
            end else if (cyc - h >= SETTLE + 1 && rsp_ready && q_id.size() != 0) begin
                total++; if (rsp_id !== q_id[0] || rsp_data !== q_data[0]) begin errs++; $display("FAIL rnd_rsp got id=%0d d=%h want %0d %h", rsp_id, rsp_data, q_id[0], q_data[0]); end else passed++;
                void'(q_id.pop_front()); void'(q_data.pop_front());
                mbusy = 0;
            end
            if (errs > 20) break;
        end
        total++; if (q_id.size() != 0) $display("FAIL rnd_drain got pend=%0d want 0", q_id.size()); else passed++;
    endtask

`ifdef TERM1_SCHED_STATS_EN
    task automatic test_stats();
        int g = 0;
        do_reset();
        req_valid = 4'b0100; rsp_ready = 1'b1;
        for (int c = 0; c < 70000 * (SETTLE + 2) + 100 && g < 70000; c++) begin
            @(negedge clk);
            if (req_ready[2]) begin
                g++;
                if (g == 70000) begin @(posedge clk); #1 req_valid = '0; end
            end
        end
        repeat (SETTLE + 4) @(posedge clk);
        #1;
        total++; if (g != 70000) $display("FAIL stats_grants got %0d want 70000", g); else passed++;
        total++; if (grant_cnt[47:32] !== 16'hFFFF) $display("FAIL stats_sat got %h want ffff", grant_cnt[47:32]); else passed++;
        total++; if (grant_cnt[31:0] !== 32'h0 || grant_cnt[63:48] !== 16'h0) $display("FAIL stats_others got %h want 0", grant_cnt); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_settle();
        test_random();
`ifdef TERM1_SCHED_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/term1_sched.md
TERM1_SCHED -- requirements
Module: term1_sched

Interface
REQ-001 The block SHALL take parameter NREQ, default 4: the number of requesters sharing one term1 instance, legal range 2..8.
REQ-002 The block SHALL take parameter SETTLE, default 2: the number of clock cycles allowed for term1 to settle before capture, legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester request strobe.
REQ-006 The block SHALL have port req_data, input, NREQ*34 bits: requester k occupies bits [34k+33:34k], ordered as the term1 inputs i0 (MSB) down to a (LSB).
REQ-007 The block SHALL have port req_ready, output, NREQ bits: per-requester accept strobe.
REQ-008 The block SHALL have port t1_in, output, 34 bits: registered drive to the shared term1 inputs, in the same bit order as req_data.
REQ-009 The block SHALL have port t1_out, input, 10 bits: term1 outputs s0 (MSB) down to j0 (LSB).
REQ-010 The block SHALL have ports rsp_valid (output, 1), rsp_id (output, clog2(NREQ)), rsp_data (output, 10) and rsp_ready (input, 1): the response channel.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have three states, IDLE, SETTLE and RESP, with one transaction in flight at most.
REQ-013 In IDLE, req_ready SHALL be combinational and one-hot for the round-robin winner among the asserted req_valid bits; it SHALL be all-zero outside IDLE and all-zero when no req_valid bit is set.
REQ-014 Round-robin order: after requester k is granted, priority SHALL run k+1, ..., NREQ-1, 0, ..., k.
REQ-015 On handshake (req_valid[k] and req_ready[k]), the block SHALL register req_data[k] into t1_in and k into rsp_id, load the settle counter with SETTLE-1, and enter SETTLE.
REQ-016 SETTLE SHALL decrement the counter each cycle; in the cycle the counter is 0, the block SHALL capture t1_out into rsp_data and enter RESP.
REQ-017 rsp_valid SHALL be high exactly while in RESP; rsp_data and rsp_id SHALL stay stable until rsp_ready is sampled high.
REQ-018 RESP with rsp_ready high SHALL return to IDLE on the next cycle, with no same-cycle re-grant; throughput SHALL be at most one transaction per SETTLE+2 cycles.
REQ-019 Latency: for a handshake in cycle 0, t1_in SHALL be valid from cycle 1 and rsp_valid SHALL rise in cycle SETTLE+1.
REQ-020 t1_in SHALL hold its last value after a transaction completes, and SHALL change only on handshake.
REQ-021 A requester that drops req_valid before being granted SHALL lose its turn silently, with no error flagged.
REQ-022 Requests that arrive while busy SHALL wait; they SHALL be neither dropped nor queued inside the block.

Reset
REQ-023 Asserting rst SHALL immediately force state to IDLE and clear t1_in, rsp_data, rsp_id, rsp_valid and the settle counter to 0.
REQ-024 Reset SHALL set the round-robin pointer so that requester 0 has first priority.
REQ-025 Reset mid-transaction SHALL abandon the transaction; no response SHALL be issued for it after reset releases.

Configuration
REQ-026 With macro TERM1_SCHED_STATS_EN defined, the block SHALL add output grant_cnt (NREQ*16 bits): per-requester 16-bit saturating counters, incremented on each handshake, holding at 0xFFFF, and cleared by rst.
REQ-027 Without TERM1_SCHED_STATS_EN, the grant_cnt port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Single request: rsp_ready=1, SETTLE=2, req_valid=0001, req_data[0]=34'h3_0000_0001 -> t1_in=34'h3_0000_0001 at cycle 1; rsp_valid=1, rsp_id=0 and rsp_data=t1_out as sampled at cycle 2, all at cycle 3.
REQ-029 Fairness: req_valid=1111 held constant -> grants issued in order 0,1,2,3,0, one every 4 cycles.
REQ-030 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_data and rsp_id held stable; req_ready stays 0000.
REQ-031 Reset in SETTLE: rst pulsed at cycle 1 -> busy=0, t1_in=0, no rsp_valid pulse; next grant goes to requester 0.
REQ-032 Stats (TERM1_SCHED_STATS_EN defined): 70000 grants to requester 2 -> grant_cnt[47:32]=16'hFFFF; other counters unchanged.
